ffe_weight_loader: RTL and testbench
====================================

Name: ffe_weight_loader

Overview:
- Configuration controller for the FFE/slicer estimator datapath.
- Accepts per-tap, per-channel weight and shift writes into a shadow bank over a valid/ready port.
- On request, commits the shadow bank atomically to the active bank that drives the datapath's weights/ffe_shift inputs.
- Then blanks est_valid for the datapath pipeline depth, so downstream logic never consumes estimates computed with mixed coefficient sets.

Parameters:
ffe_length, 10, number of FFE taps
channel_width, 16, parallel channels
weight_precision, 10, signed weight width
shift_precision, 5, per-channel shift width
flush_cycles, 3, cycles est_valid stays low after a commit (datapath depth)

Ports:
clk  input  1  clock
rstb  input  1  asynchronous active-low reset
wr_valid  input  1  write request
wr_ready  output  1  write accept
wr_tap  input  $clog2(ffe_length)  target tap
wr_chan  input  $clog2(channel_width)  target channel
wr_bcast  input  1  write all channels; wr_chan ignored
wr_shift  input  1  1 = write ffe_shift (tap ignored), 0 = write weight
wr_data  input  weight_precision  signed data; shift uses low shift_precision bits
commit_req  input  1  commit request pulse/level (rising edge detected)
commit_ack  output  1  one-cycle pulse when the active bank updates
weights  output  signed weight_precision [ffe_length][channel_width]  active weights
ffe_shift  output  shift_precision [channel_width]  active shifts
est_valid  output  1  datapath output trustworthy
busy  output  1  state != IDLE or commit pending
err_sticky  output  1  out-of-range write seen; cleared only by reset

Behaviour:
- Clock is clk; reset is asynchronous and active-low on rstb.
- Reset values:
  - shadow and active weights/shifts = 0
  - commit_ack = 0, est_valid = 0, err_sticky = 0, pending = 0
  - wr_ready = 1
  - state = FLUSH with cnt = flush_cycles, so est_valid rises flush_cycles cycles after reset release
- FSM states: IDLE, COMMIT, FLUSH.
- IDLE:
  - est_valid = 1, wr_ready = 1.
  - If pending = 1, go to COMMIT.
- COMMIT (exactly 1 cycle):
  - wr_ready = 0, est_valid = 0.
  - At the closing edge: active <= shadow (all taps and shifts in one edge), pending <= 0, commit_ack <= 1 for the next cycle, cnt <= flush_cycles.
  - Next state is FLUSH, or IDLE if flush_cycles = 0.
- FLUSH:
  - est_valid = 0, wr_ready = 1.
  - cnt decrements each cycle; when cnt = 1 the next state is IDLE.
- Write handshake:
  - A write is accepted on an edge with wr_valid && wr_ready and updates only the shadow bank.
  - Zero-cycle turnaround: back-to-back accepts are allowed every cycle wr_ready = 1.
- Broadcast: wr_bcast = 1 writes wr_data to every channel of wr_tap (or every channel's shift when wr_shift = 1).
- Range check: wr_tap >= ffe_length with wr_shift = 0, or wr_chan >= channel_width with wr_bcast = 0:
  - The write is still accepted (handshake completes).
  - Shadow is unchanged and err_sticky <= 1.
- Commit request:
  - commit_req is registered and its rising edge sets pending.
  - Multiple edges before service merge into one commit.
  - An edge arriving in the same cycle pending clears re-sets pending, so a second commit follows.
- Simultaneous write and entry to COMMIT: a write accepted on the edge IDLE->COMMIT is included in the commit, because the shadow is updated before the copy.
- Commit requested during FLUSH: held pending and serviced immediately on IDLE entry. IDLE then lasts 1 cycle with est_valid = 1.
- Active outputs are stable between commits; they never change while est_valid = 1.
- Reset mid-operation (any state): all of the above reset values apply asynchronously, and uncommitted shadow data is lost.

Test Plan:
- Reset release:
  - est_valid = 0 for 3 cycles, then 1.
  - All weights = 0, wr_ready = 1, err_sticky = 0.
- Write w[2][5] = -37 with no commit:
  - weights[2][5] stays 0 for 20 cycles.
  - Then pulse commit_req: commit_ack pulses 2 cycles after the edge, weights[2][5] = -37 in the ack cycle, est_valid = 0 for 1 + 3 cycles, then 1.
- Broadcast tap 0 = 511 plus shift broadcast = 7, then commit:
  - All 16 channels show weights[0][*] = 511 and ffe_shift[*] = 7 on the same edge.
- Write wr_tap = 12, then commit:
  - err_sticky = 1 and the active bank is unchanged.
  - A later valid write still works.
- commit_req pulsed during FLUSH, plus a write accepted in the same cycle IDLE->COMMIT:
  - A second commit_ack follows, and the second commit includes that write.
- Assert rstb low in the COMMIT cycle:
  - The active bank stays 0 (no partial copy), commit_ack = 0, and the FSM restarts in FLUSH.

Source files
------------

// File: rtl/ffe_weight_loader.sv
// ffe_weight_loader
//   Coefficient loader for the FFE/slicer estimator datapath. Writes land in a
//   shadow bank; a commit copies the whole shadow bank to the active bank in a
//   single edge, then holds est_valid low for flush_cycles so nothing computed
//   with a mix of old and new coefficients is used downstream.
//
// Ports
//   clk, rstb        clock, asynchronous active-low reset
//   wr_valid/ready   write handshake (accept on wr_valid && wr_ready)
//   wr_tap, wr_chan  write target; wr_bcast hits every channel of the tap
//   wr_shift         1 = write the channel shift (tap ignored), 0 = weight
//   wr_data          signed data; shifts take the low shift_precision bits
//   commit_req       rising edge requests a shadow->active commit
//   commit_ack       one-cycle pulse in the cycle after the active bank updates
//   weights          active weights [tap][channel]
//   ffe_shift        active per-channel shifts
//   est_valid        datapath output may be consumed
//   busy             not idle, or a commit is pending
//   err_sticky       an out-of-range write was seen (cleared only by reset)
module ffe_weight_loader #(
  parameter int ffe_length       = 10,
  parameter int channel_width    = 16,
  parameter int weight_precision = 10,
  parameter int shift_precision  = 5,
  parameter int flush_cycles     = 3,
  localparam int tap_w  = (ffe_length > 1) ? $clog2(ffe_length) : 1,
  localparam int chan_w = (channel_width > 1) ? $clog2(channel_width) : 1,
  localparam int cnt_w  = (flush_cycles > 0) ? $clog2(flush_cycles + 1) : 1
) (
  input  logic                               clk,
  input  logic                               rstb,
  input  logic                               wr_valid,
  output logic                               wr_ready,
  input  logic [tap_w-1:0]                   wr_tap,
  input  logic [chan_w-1:0]                  wr_chan,
  input  logic                               wr_bcast,
  input  logic                               wr_shift,
  input  logic signed [weight_precision-1:0] wr_data,
  input  logic                               commit_req,
  output logic                               commit_ack,
  output logic signed [weight_precision-1:0] weights [ffe_length][channel_width],
  output logic [shift_precision-1:0]         ffe_shift [channel_width],
  output logic                               est_valid,
  output logic                               busy,
  output logic                               err_sticky
);

  typedef enum logic [1:0] {IDLE, COMMIT, FLUSH} state_t;

  state_t                            state, state_d;
  logic [cnt_w-1:0]                  cnt, cnt_d;
  logic                              req_q;
  logic                              pending;
  logic signed [weight_precision-1:0] shadow_w [ffe_length][channel_width];
  logic [shift_precision-1:0]        shadow_s [channel_width];

  logic wr_fire, tap_bad, chan_bad, wr_ok, req_rise;

  // The tap only matters for weight writes, the channel only for non-broadcast
  // writes; a bad write still completes its handshake.
  assign wr_fire  = wr_valid && wr_ready;
  assign tap_bad  = !wr_shift && (int'(wr_tap) >= ffe_length);
  assign chan_bad = !wr_bcast && (int'(wr_chan) >= channel_width);
  assign wr_ok    = wr_fire && !tap_bad && !chan_bad;
  assign req_rise = commit_req && !req_q;
  assign busy     = (state != IDLE) || pending;

  // Shadow bank. A write on the IDLE->COMMIT edge lands here before the copy
  // at the end of COMMIT, so it is part of that commit.
  // NOTE: both banks are architecturally visible and must read zero after
  // reset, so they are reset explicitly even though that costs reset fan-out.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      for (int t = 0; t < ffe_length; t++)
        for (int c = 0; c < channel_width; c++)
          shadow_w[t][c] <= '0;
      for (int c = 0; c < channel_width; c++)
        shadow_s[c] <= '0;
    end else if (wr_ok) begin
      for (int c = 0; c < channel_width; c++) begin
        if (wr_bcast || (chan_w'(c) == wr_chan)) begin
          if (wr_shift) shadow_s[c] <= wr_data[shift_precision-1:0];
          else          shadow_w[wr_tap][c] <= wr_data;
        end
      end
    end
  end

  // Active bank: only ever changes at the closing edge of COMMIT.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      for (int t = 0; t < ffe_length; t++)
        for (int c = 0; c < channel_width; c++)
          weights[t][c] <= '0;
      for (int c = 0; c < channel_width; c++)
        ffe_shift[c] <= '0;
    end else if (state == COMMIT) begin
      weights   <= shadow_w;
      ffe_shift <= shadow_s;
    end
  end

  // Control state. Reset lands in FLUSH so est_valid waits for the datapath
  // to fill after reset, exactly as after a commit.
  // NOTE: non-blocking assignments keep every register sampling the pre-edge
  // value of its neighbours, regardless of block ordering.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state      <= (flush_cycles == 0) ? IDLE : FLUSH;
      cnt        <= cnt_w'(flush_cycles);
      req_q      <= 1'b0;
      pending    <= 1'b0;
      commit_ack <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      req_q      <= commit_req;
      commit_ack <= (state == COMMIT);
      // A new request edge in the commit cycle wins over the clear, so it
      // produces a second commit instead of being lost.
      if (req_rise)              pending <= 1'b1;
      else if (state == COMMIT)  pending <= 1'b0;
      if (wr_fire && (tap_bad || chan_bad)) err_sticky <= 1'b1;
    end
  end

  // NOTE: every output of this block gets a default first so no path through
  // the case statement can infer a latch.
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    est_valid = 1'b0;
    wr_ready  = 1'b1;
    case (state)
      IDLE: begin
        est_valid = 1'b1;
        if (pending) state_d = COMMIT;
      end
      COMMIT: begin
        wr_ready = 1'b0;
        cnt_d    = cnt_w'(flush_cycles);
        state_d  = (flush_cycles == 0) ? IDLE : FLUSH;
      end
      FLUSH: begin
        cnt_d = cnt - cnt_w'(1);
        if (cnt <= cnt_w'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ffe_weight_loader.sv
// Self-checking bench for ffe_weight_loader: a timer-based reference model
// (banks as int arrays, est_valid as a blanking countdown) checked every
// cycle, plus hand-computed literal expectations for the directed scenarios.
module tb_ffe_weight_loader;

  localparam int FL = 10;
  localparam int CW = 16;
  localparam int WP = 10;
  localparam int SP = 5;
  localparam int FC = 3;
  localparam int TW = 4;
  localparam int CHW = 4;

  logic                 clk = 1'b0;
  logic                 rstb = 1'b0;
  logic                 wr_valid = 1'b0;
  logic                 wr_ready;
  logic [TW-1:0]        wr_tap = '0;
  logic [CHW-1:0]       wr_chan = '0;
  logic                 wr_bcast = 1'b0;
  logic                 wr_shift = 1'b0;
  logic signed [WP-1:0] wr_data = '0;
  logic                 commit_req = 1'b0;
  logic                 commit_ack;
  logic signed [WP-1:0] weights [FL][CW];
  logic [SP-1:0]        ffe_shift [CW];
  logic                 est_valid;
  logic                 busy;
  logic                 err_sticky;

  int n_checks = 0;
  int n_errors = 0;

  ffe_weight_loader #(
    .ffe_length(FL), .channel_width(CW), .weight_precision(WP),
    .shift_precision(SP), .flush_cycles(FC)
  ) dut (
    .clk(clk), .rstb(rstb), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_tap(wr_tap), .wr_chan(wr_chan), .wr_bcast(wr_bcast),
    .wr_shift(wr_shift), .wr_data(wr_data), .commit_req(commit_req),
    .commit_ack(commit_ack), .weights(weights), .ffe_shift(ffe_shift),
    .est_valid(est_valid), .busy(busy), .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int m_sh_w [FL][CW];
  int m_sh_s [CW];
  int m_ac_w [FL][CW];
  int m_ac_s [CW];
  int m_blank;      // low cycles still to come before est_valid returns
  bit m_commit;     // current cycle is the copy cycle
  bit m_pend, m_ack, m_err, m_req_prev;

  always @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      for (int t = 0; t < FL; t++)
        for (int c = 0; c < CW; c++) begin m_sh_w[t][c] = 0; m_ac_w[t][c] = 0; end
      for (int c = 0; c < CW; c++) begin m_sh_s[c] = 0; m_ac_s[c] = 0; end
      m_blank = FC; m_commit = 0; m_pend = 0; m_ack = 0; m_err = 0; m_req_prev = 0;
    end else begin
      bit was_commit, rise;
      was_commit = m_commit;
      if (wr_valid && !was_commit) begin
        if ((!wr_shift && int'(wr_tap) >= FL) || (!wr_bcast && int'(wr_chan) >= CW))
          m_err = 1;
        else
          for (int c = 0; c < CW; c++)
            if (wr_bcast || c == int'(wr_chan)) begin
              if (wr_shift) m_sh_s[c] = int'(wr_data[SP-1:0]);
              else          m_sh_w[int'(wr_tap)][c] = int'(wr_data);
            end
      end
      if (was_commit) begin m_ac_w = m_sh_w; m_ac_s = m_sh_s; end
      m_ack = was_commit;
      rise = commit_req && !m_req_prev;
      m_req_prev = commit_req;
      if (was_commit)       begin m_commit = 0; m_blank = FC; end
      else if (m_blank > 0) m_blank--;
      else if (m_pend)      m_commit = 1;
      m_pend = was_commit ? rise : (m_pend || rise);
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rstb) begin
      bit exp_valid;
      exp_valid = !m_commit && (m_blank == 0);
      check("est_valid", int'(est_valid), int'(exp_valid));
      check("wr_ready", int'(wr_ready), int'(!m_commit));
      check("commit_ack", int'(commit_ack), int'(m_ack));
      check("busy", int'(busy), int'(!exp_valid || m_pend));
      check("err_sticky", int'(err_sticky), int'(m_err));
      for (int t = 0; t < FL; t++)
        for (int c = 0; c < CW; c++)
          check($sformatf("weights[%0d][%0d]", t, c), int'(weights[t][c]), m_ac_w[t][c]);
      for (int c = 0; c < CW; c++)
        check($sformatf("ffe_shift[%0d]", c), int'(ffe_shift[c]), m_ac_s[c]);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wr(input int tap, input int chan, input bit bc, input bit sh, input int data);
    @(negedge clk);
    wr_valid = 1'b1; wr_tap = TW'(tap); wr_chan = CHW'(chan);
    wr_bcast = bc; wr_shift = sh; wr_data = WP'(data);
    for (int i = 0; i < 20 && !wr_ready; i++) @(negedge clk);
    check("wr_ready_wait", int'(wr_ready), 1);
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic pulse_commit();
    @(negedge clk) commit_req = 1'b1;
    @(negedge clk) commit_req = 1'b0;
  endtask

  task automatic wait_ack(output int lat);
    lat = 0;
    while (!commit_ack && lat < 50) begin @(negedge clk); lat++; end
    check("ack_seen", int'(commit_ack), 1);
  endtask

  task automatic release_reset();
    int n;
    repeat (2) @(negedge clk);
    rstb = 1'b1;
    n = 0;
    while (!est_valid && n < 20) begin @(negedge clk); n++; end
    check("reset_valid_delay", n, FC);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, n;

    // Reset release
    release_reset();
    check("rst_w00", int'(weights[0][0]), 0);
    check("rst_w915", int'(weights[9][15]), 0);
    check("rst_ready", int'(wr_ready), 1);
    check("rst_err", int'(err_sticky), 0);

    // Single write stays in the shadow bank until committed
    wr(2, 5, 0, 0, -37);
    repeat (20) @(negedge clk);
    check("w25_uncommitted", int'(weights[2][5]), 0);
    pulse_commit();
    wait_ack(lat);
    check("ack_latency", lat, 2);
    check("w25_in_ack", int'(weights[2][5]), -37);
    n = 0;
    while (!est_valid && n < 20) begin n++; @(negedge clk); end
    check("flush_low_cycles", n, FC);

    // Back-to-back burst: broadcasts, extreme values, shift write with tap out of range
    @(negedge clk);
    wr_valid = 1; wr_bcast = 1; wr_shift = 0; wr_tap = 0; wr_chan = 0; wr_data = 10'sd511;
    @(negedge clk); wr_shift = 1; wr_data = 10'sd7;
    @(negedge clk); wr_bcast = 0; wr_shift = 0; wr_tap = 9; wr_chan = 15; wr_data = -10'sd512;
    @(negedge clk); wr_shift = 1; wr_tap = 15; wr_chan = 4; wr_data = 10'sd3;
    @(negedge clk); wr_valid = 0;
    check("shift_tap_ignored_err", int'(err_sticky), 0);
    pulse_commit();
    wait_ack(lat);
    for (int c = 0; c < CW; c++) begin
      check($sformatf("bcast_w0[%0d]", c), int'(weights[0][c]), 511);
      check($sformatf("bcast_sh[%0d]", c), int'(ffe_shift[c]), (c == 4) ? 3 : 7);
    end
    check("w9_15_min", int'(weights[9][15]), -512);

    // Out-of-range tap: accepted, flagged, ignored
    wr(12, 0, 0, 0, 100);
    check("err_set", int'(err_sticky), 1);
    pulse_commit();
    wait_ack(lat);
    check("bad_keeps_w25", int'(weights[2][5]), -37);
    check("bad_keeps_w03", int'(weights[0][3]), 511);
    wr(3, 1, 0, 0, 5);
    pulse_commit();
    wait_ack(lat);
    check("good_after_bad", int'(weights[3][1]), 5);
    check("err_still_set", int'(err_sticky), 1);

    // Request during FLUSH plus write on the IDLE->COMMIT edge
    wr(1, 1, 0, 0, 11);
    @(negedge clk) commit_req = 1;
    wait_ack(lat);
    commit_req = 0;
    check("first_commit_w11", int'(weights[1][1]), 11);
    @(negedge clk) commit_req = 1;
    @(negedge clk) commit_req = 0;
    n = 0;
    while (!est_valid && n < 20) begin @(negedge clk); n++; end
    wr_valid = 1; wr_bcast = 0; wr_shift = 0; wr_tap = 7; wr_chan = 8; wr_data = -10'sd200;
    @(negedge clk);
    wr_valid = 0;
    check("idle_one_cycle", int'(est_valid), 0);
    check("in_commit_ready", int'(wr_ready), 0);
    check("w78_not_yet", int'(weights[7][8]), 0);
    wait_ack(lat);
    check("second_commit_w78", int'(weights[7][8]), -200);

    // Reset asserted in the COMMIT cycle
    wr(4, 4, 0, 0, 77);
    pulse_commit();
    n = 0;
    while (wr_ready && n < 20) begin @(negedge clk); n++; end
    check("reached_commit", int'(wr_ready), 0);
    rstb = 0;
    #1;
    check("rst_mid_ack", int'(commit_ack), 0);
    check("rst_mid_w44", int'(weights[4][4]), 0);
    check("rst_mid_w78", int'(weights[7][8]), 0);
    check("rst_mid_valid", int'(est_valid), 0);
    check("rst_mid_ready", int'(wr_ready), 1);
    check("rst_mid_err", int'(err_sticky), 0);
    release_reset();
    pulse_commit();
    wait_ack(lat);
    check("shadow_lost_w44", int'(weights[4][4]), 0);
    check("shadow_lost_w25", int'(weights[2][5]), 0);

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
